// File: rtl/lenet_5_pkg.sv
// lenet_5_pkg: shared constants and types for the lenet_5 output stage
package lenet_5_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int DATA_WIDTH = 16;
  localparam int LABEL_WIDTH = $clog2(NUM_CLASSES);
  typedef logic signed [DATA_WIDTH-1:0] score_t;
  typedef enum logic [1:0] {SCAN, EMIT, DONE} state_t;
endpackage

// File: rtl/lenet_5_argmax_scorer_argmax_tracker.sv
// argmax_tracker: running signed maximum and its class index over one image
module argmax_tracker #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LABEL_WIDTH = $clog2(NUM_CLASSES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         accept,
  input  logic signed [DATA_WIDTH-1:0] score,
  output logic                         first,
  output logic                         last,
  output logic [LABEL_WIDTH-1:0]       next_argmax
);
  logic [LABEL_WIDTH-1:0] index, argmax;
  logic signed [DATA_WIDTH-1:0] max;
  logic greater;
  assign first = index == '0;
  assign last = index == LABEL_WIDTH'(NUM_CLASSES - 1);
  assign greater = score > max;
  // strict compare: ties keep the earlier class
  assign next_argmax = first ? '0 : greater ? index : argmax;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index <= '0;
      max <= '0;
      argmax <= '0;
    end else if (accept) begin
      max <= (first || greater) ? score : max;
      argmax <= next_argmax;
      index <= last ? '0 : index + 1'b1;
    end
  end
endmodule

// File: rtl/lenet_5_argmax_scorer.sv
// lenet_5_argmax_scorer: per-image arg-max, label check and running accuracy counts
module lenet_5_argmax_scorer import lenet_5_pkg::*; #(
  parameter int NUM_CLASSES = lenet_5_pkg::NUM_CLASSES,
  parameter int DATA_WIDTH = lenet_5_pkg::DATA_WIDTH,
  parameter int NUM_IMAGES = 10_000,
  parameter int LABEL_WIDTH = $clog2(NUM_CLASSES),
  parameter int COUNT_WIDTH = $clog2(NUM_IMAGES + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         score_valid,
  input  logic signed [DATA_WIDTH-1:0] score,
  output logic                         score_ready,
  input  logic [LABEL_WIDTH-1:0]       label,
  output logic [LABEL_WIDTH-1:0]       prediction,
  output logic                         prediction_correct,
  output logic                         prediction_valid,
  output logic [COUNT_WIDTH-1:0]       image_count,
  output logic [COUNT_WIDTH-1:0]       correct_count,
  output logic                         output_ready
);
  state_t state;
  logic accept, first, last, hit;
  logic [LABEL_WIDTH-1:0] next_argmax, label_reg;
  logic [COUNT_WIDTH-1:0] next_count;
  assign score_ready = enable && state == SCAN;
  assign accept = score_valid && score_ready;
  assign hit = next_argmax == label_reg;
  assign next_count = image_count + 1'b1;
  argmax_tracker #(
    .NUM_CLASSES(NUM_CLASSES),
    .DATA_WIDTH(DATA_WIDTH),
    .LABEL_WIDTH(LABEL_WIDTH)
  ) u_tracker (
    .clock(clock),
    .reset(reset),
    .accept(accept),
    .score(score),
    .first(first),
    .last(last),
    .next_argmax(next_argmax)
  );
  // results are registered on the final accept so they are all visible during EMIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      label_reg <= '0;
      prediction <= '0;
      prediction_correct <= 1'b0;
      prediction_valid <= 1'b0;
      image_count <= '0;
      correct_count <= '0;
      output_ready <= 1'b0;
    end else begin
      prediction_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (accept && first) label_reg <= label;
          if (accept && last) begin
            state <= EMIT;
            prediction_valid <= 1'b1;
            prediction <= next_argmax;
            prediction_correct <= hit;
            image_count <= next_count;
            correct_count <= correct_count + COUNT_WIDTH'(hit);
            output_ready <= next_count == COUNT_WIDTH'(NUM_IMAGES);
          end
        end
        EMIT: state <= output_ready ? DONE : SCAN;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/lenet_5_argmax_scorer.md
Name: lenet_5_argmax_scorer

Overview:
- Downstream stage of lenet_5. Consumes the NUM_CLASSES output-layer scores of each image, streamed one per cycle.
- Picks the arg-max class and compares it with the image's reference label.
- Keeps running image and correct-prediction counts.
- Raises output_ready once NUM_IMAGES images have been classified. This is the completion signal the top-level bench polls.

Parameters:
- NUM_CLASSES, 10, output neurons per image.
- DATA_WIDTH, 16, signed fixed-point score width.
- NUM_IMAGES, 10_000, images per run.
- LABEL_WIDTH, $clog2(NUM_CLASSES), class index width.
- COUNT_WIDTH, $clog2(NUM_IMAGES+1), counter width.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  global run enable; low stalls score acceptance.
- score_valid  in  1  score present on score.
- score  in  DATA_WIDTH  signed score, class order 0..NUM_CLASSES-1.
- score_ready  out  1  stage accepts a score this cycle.
- label  in  LABEL_WIDTH  reference label; sampled with score index 0.
- prediction  out  LABEL_WIDTH  arg-max class of last completed image.
- prediction_correct  out  1  prediction == sampled label.
- prediction_valid  out  1  one-cycle pulse per completed image.
- image_count  out  COUNT_WIDTH  images completed.
- correct_count  out  COUNT_WIDTH  correct predictions.
- output_ready  out  1  sticky; all NUM_IMAGES done.

Behaviour:
- Reset: state=SCAN; index=0; max=0; argmax=0; label_reg=0. All outputs 0: prediction, prediction_correct, prediction_valid, image_count, correct_count, output_ready.
- score_ready = enable && state==SCAN (combinational).
- An accept is score_valid && score_ready.
- States:
  - SCAN: on each accept:
    - index 0: max<=score, argmax<=0, label_reg<=label.
    - index k>0: if score > max (signed, strict), max<=score and argmax<=k. Ties keep the lower index.
    - index NUM_CLASSES-1: index<=0 and go to EMIT. Otherwise index<=index+1.
    - No accept leaves state unchanged. Gaps and enable-low cycles are legal anywhere.
  - EMIT (exactly one cycle, independent of enable):
    - prediction_valid=1; prediction<=argmax; prediction_correct<=(argmax==label_reg).
    - image_count+1; correct_count+1 if correct.
    - If the new image_count==NUM_IMAGES: go to DONE and set output_ready the same cycle. Else go to SCAN.
  - DONE: terminal until reset. score_ready=0, score_valid ignored, outputs frozen.
- Argmax must include the last score. Use the combinational next-argmax in the final accept cycle, so EMIT reads fully registered values.
- Latency: prediction_valid is high in the cycle after the NUM_CLASSES-th accept. Max throughput is one image per NUM_CLASSES+1 cycles.
- prediction and prediction_correct hold their values until the next EMIT.
- Label >= NUM_CLASSES never matches; it counts as incorrect.
- Counters saturate by construction (max NUM_IMAGES); no wrap.
- Reset mid-image discards the partial image. The next accepted score is index 0.
- Signed compare on full DATA_WIDTH; no truncation.

Decomposition:
- lenet_5_pkg:
  - NUM_CLASSES and LABEL_WIDTH constants.
  - score_t typedef (logic signed [DATA_WIDTH-1:0]).
  - state_t enum {SCAN, EMIT, DONE}.
- One natural sub-module, argmax_tracker: holds max/argmax/index and exposes next_argmax plus a last-accept flag. The FSM and counters stay in the parent.

Test Plan:
1. Reset held, then released with enable=1 -> all outputs 0, score_ready=1 the next cycle. Assert reset mid-run -> counters return to 0 asynchronously.
2. Scores {-5,3,7,2,7,0,-1,1,6,-8}, label=2, back-to-back -> prediction=2 (tie keeps 2), prediction_correct=1, correct_count=1, prediction_valid exactly 1 cycle after the 10th accept.
3. All ten scores = -32768, label=0 -> prediction=0, correct. Then scores with max at index 9 (=32767), label=4 -> prediction=9, prediction_correct=0, image_count=2, correct_count=1.
4. Image from 2 with random score_valid gaps and enable low for 3 cycles after the 4th score -> score_ready low while enable low, exactly 10 accepts, same result as scenario 2.
5. NUM_IMAGES=3, three images (2 correct) -> output_ready rises in the third EMIT cycle and stays high, image_count=3, correct_count=2. Further score_valid -> no accepts, outputs unchanged.
6. Reset after 5 accepted scores, then a full 10-score image with label=7 and max at index 7 -> prediction=7, image_count=1, no contamination from the discarded scores.
